// File: rtl/pattern_detect_pkg.sv
// Shared constants and elaboration-time helpers for the pattern detector.
package pattern_detect_pkg;

   // Largest pattern length the detector is meant to support.
   localparam int unsigned PAT_W_MAX = 16;

   // Ceiling log2, used for sizing the history fill counter.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(n)) begin
         r++;
      end
      return r;
   endfunction

   // All-ones value of the given width (1..32), returned in 32 bits.
   function automatic logic [31:0] all_ones(input int unsigned w);
      logic [31:0] v;
      v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return v;
   endfunction

endpackage

// File: rtl/pattern_detect_param_if.sv
// Serial-input, pattern-control and status bundle of the pattern detector.
interface pattern_detect_param_if #(
   parameter int unsigned PAT_W = 3,
   parameter int unsigned CNT_W = 10
);
   logic             en;
   logic             x;
   logic             pat_ld;
   logic [PAT_W-1:0] pat_in;
   logic             overlap;
   logic             cnt_clr;
   logic             y;
   logic [CNT_W-1:0] count;
   logic             cnt_sat;

   // Driver side: supplies the bit stream and controls, observes status.
   modport master (
      output en, x, pat_ld, pat_in, overlap, cnt_clr,
      input  y, count, cnt_sat
   );

   // Detector side.
   modport slave (
      input  en, x, pat_ld, pat_in, overlap, cnt_clr,
      output y, count, cnt_sat
   );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and a clear that
// never swallows a simultaneous increment.
module sat_counter
   import pattern_detect_pkg::*;
#(
   parameter int unsigned CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(all_ones(CNT_W));

   logic [CNT_W-1:0] r_count;
   logic             r_sat;

   // Count update: clear wins over the old value but still records a same-cycle event.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (i_clr) begin
         r_count <= i_inc ? CNT_W'(1) : '0;
         r_sat   <= 1'b0;
      end else if (i_inc) begin
         if (r_count == CNT_MAX) begin
            r_sat <= 1'b1;
         end else begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign o_count = r_count;
   assign o_sat   = r_sat;

endmodule

// File: rtl/pattern_detect_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, overlapping or
// non-overlapping matching, a bit-valid qualifier and a saturating match count.
module pattern_detect_param
   import pattern_detect_pkg::*;
#(
   parameter int unsigned     PAT_W   = 3,
   parameter int unsigned     CNT_W   = 10,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(3'b010)
) (
   input logic                 clk,
   input logic                 rst,
   pattern_detect_param_if.slave bus
);

   localparam int unsigned      FILL_W   = (clog2(PAT_W) < 1) ? 1 : clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  r_pat;
   logic [PAT_W-2:0]  r_sh;
   logic [FILL_W-1:0] r_fill;
   logic              r_y;

   logic [PAT_W-1:0]  w_win;
   logic              w_match;
   logic [CNT_W-1:0]  w_count;
   logic              w_sat;

   // Match only once a full window of valid bits has been collected.
   always_comb begin
      w_win   = {r_sh, bus.x};
      w_match = 1'b0;
      if (bus.en && !bus.pat_ld && (r_fill == FILL_MAX) && (w_win == r_pat)) begin
         w_match = 1'b1;
      end
   end

   // Pattern register, history shift, fill tracking and registered match pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pat  <= PAT_RST;
         r_sh   <= '0;
         r_fill <= '0;
         r_y    <= 1'b0;
      end else if (bus.pat_ld) begin
         // The bit presented during a load is dropped.
         r_pat  <= bus.pat_in;
         r_sh   <= '0;
         r_fill <= '0;
         r_y    <= 1'b0;
      end else if (bus.en) begin
         r_y <= w_match;
         if (w_match && !bus.overlap) begin
            r_sh   <= '0;
            r_fill <= '0;
         end else begin
            r_sh <= w_win[PAT_W-2:0];
            if (r_fill != FILL_MAX) begin
               r_fill <= r_fill + FILL_W'(1);
            end
         end
      end else begin
         r_y <= 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_sat_counter (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_match),
      .i_clr   (bus.cnt_clr),
      .o_count (w_count),
      .o_sat   (w_sat)
   );

   assign bus.y       = r_y;
   assign bus.count   = w_count;
   assign bus.cnt_sat = w_sat;

endmodule
